// File: rtl/wr_pps_mon_pkg.sv
// wr_pps_mon_pkg: channel FSM states and lane-packing helper shared by the PPS monitor.
package wr_pps_mon_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, LOCKED, LOST} state_t;

    // LSB of lane k when w-bit fields are packed side by side
    function automatic int lane_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/wr_pps_mon_chan.sv
// wr_pps_mon_chan: one PPS channel -- synchroniser, edge detect, period FSM,
// lost-PPS timeout and edge counter.
module wr_pps_mon_chan
    import wr_pps_mon_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int NOMINAL_CLKS = 62500000,
    parameter int TOL_CLKS     = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pps,
    input  logic             clr,
    output logic             pulse,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             period_err,
    output logic             lost
);

    localparam logic [63:0] LIMIT = 64'(NOMINAL_CLKS) + 64'(TOL_CLKS);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    state_t                 state;
    logic [CNT_W-1:0]       ivl;
    logic                   active;
    logic                   timeout;
    logic                   out_of_tol;

    assign active     = state == ARMED || state == LOCKED;
    assign timeout    = 64'(ivl) == LIMIT;
    assign out_of_tol = 64'(ivl) > LIMIT || 64'(ivl) + 64'(TOL_CLKS) < 64'(NOMINAL_CLKS);
    assign lost       = state == LOST;

    // pulse is the edge event for everything downstream; an edge always beats the timeout
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync         <= '0;
            prev         <= 1'b0;
            pulse        <= 1'b0;
            ivl          <= '0;
            count        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            period_err   <= 1'b0;
            state        <= IDLE;
        end else begin
            sync         <= {sync[SYNC_STAGES-2:0], pps};
            prev         <= sync[SYNC_STAGES-1];
            pulse        <= sync[SYNC_STAGES-1] & ~prev;
            ivl          <= pulse ? CNT_W'(1) : ivl + CNT_W'(~&ivl);
            count        <= clr ? '0 : count + CNT_W'(pulse);
            period_err   <= !clr && (period_err || (pulse && active && out_of_tol));
            period       <= pulse && active ? ivl : period;
            period_valid <= pulse && active ? 1'b1 : (active && timeout ? 1'b0 : period_valid);
            state        <= pulse ? (active ? LOCKED : ARMED) : (active && timeout ? LOST : state);
        end

endmodule

// File: rtl/wr_pps_monitor.sv
// wr_pps_monitor: N_CH-channel PPS and clock monitor on the WR system clock.
// Define WR_PPS_MON_TS_EN to add per-channel edge timestamps on ts_o.
module wr_pps_monitor
    import wr_pps_mon_pkg::*;
#(
    parameter int N_CH         = 2,
    parameter int CNT_W        = 32,
    parameter int NOMINAL_CLKS = 62500000,
    parameter int TOL_CLKS     = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clk_sys_i,
    input  logic                  rst_n_i,
    input  logic [N_CH-1:0]       pps_i,
    input  logic                  clr_i,
    output logic [CNT_W-1:0]      clk_counter_o,
    output logic [N_CH-1:0]       pps_pulse_o,
    output logic [N_CH*CNT_W-1:0] pps_counter_o,
    output logic [N_CH*CNT_W-1:0] period_o,
    output logic [N_CH-1:0]       period_valid_o,
    output logic [N_CH-1:0]       period_err_o,
    output logic [N_CH-1:0]       pps_lost_o
`ifdef WR_PPS_MON_TS_EN
    ,
    output logic [N_CH*CNT_W-1:0] ts_o
`endif
);

    always_ff @(posedge clk_sys_i or negedge rst_n_i)
        if (!rst_n_i) clk_counter_o <= '0;
        else          clk_counter_o <= clr_i ? '0 : clk_counter_o + CNT_W'(1);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        localparam int LSB = lane_lsb(k, CNT_W);

        wr_pps_mon_chan #(
            .CNT_W       (CNT_W),
            .NOMINAL_CLKS(NOMINAL_CLKS),
            .TOL_CLKS    (TOL_CLKS),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk         (clk_sys_i),
            .rst_n       (rst_n_i),
            .pps         (pps_i[k]),
            .clr         (clr_i),
            .pulse       (pps_pulse_o[k]),
            .count       (pps_counter_o[LSB +: CNT_W]),
            .period      (period_o[LSB +: CNT_W]),
            .period_valid(period_valid_o[k]),
            .period_err  (period_err_o[k]),
            .lost        (pps_lost_o[k])
        );

`ifdef WR_PPS_MON_TS_EN
        // captures the pre-increment clock count of the pulse cycle
        logic [CNT_W-1:0] ts;
        always_ff @(posedge clk_sys_i or negedge rst_n_i)
            if (!rst_n_i) ts <= '0;
            else          ts <= clr_i ? '0 : (pps_pulse_o[k] ? clk_counter_o : ts);
        assign ts_o[LSB +: CNT_W] = ts;
`endif
    end

endmodule
